// File: rtl/pe_scheduler.sv
// PE scheduler: unpacks one NoC configuration packet into filter/ifmap memory writes,
// starts the PE, forwards each returned psum as an output packet and waits for done.
package pe_scheduler_pkg;

  localparam int unsigned PKT_W = 39;

  // Incoming configuration packet; f[2] holds packet bits 23:16 (filter word 0)
  // and ifmap bit 4 holds packet bit 28 (ifmap[0]).
  typedef struct packed {
    logic [1:0]      typ;
    logic [7:0]      header;
    logic [4:0]      ifmap;
    logic [2:0][7:0] f;
  } in_pkt_t;

  typedef struct packed {
    logic [1:0]  typ;
    logic [7:0]  header;
    logic        pad;
    logic [1:0]  row;
    logic [1:0]  col;
    logic [15:0] zero;
    logic [7:0]  psum;
  } out_pkt_t;

  localparam logic [1:0] TYPE_CFG  = 2'b01;
  localparam logic [1:0] TYPE_PSUM = 2'b10;

endpackage

module pe_scheduler
  import pe_scheduler_pkg::*;
#(
  parameter int unsigned WIDTH   = 39,
  parameter int unsigned WIDTH_F = 8,
  parameter int unsigned DEPTH_F = 3,
  parameter int unsigned DEPTH_I = 5,
  parameter int unsigned ADDR_F  = 2,
  parameter int unsigned ADDR_I  = 3,
  parameter logic [1:0]  OUT_ROW = 2'b01
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   pkt_in_data,
  input  logic               pkt_in_valid,
  output logic               pkt_in_ready,
  output logic               f_we,
  output logic [ADDR_F-1:0]  f_addr,
  output logic [WIDTH_F-1:0] f_wdata,
  output logic               i_we,
  output logic [ADDR_I-1:0]  i_addr,
  output logic               i_wdata,
  output logic               start,
  input  logic [7:0]         psum_data,
  input  logic               psum_valid,
  output logic               psum_ready,
  input  logic               done,
  output logic [WIDTH-1:0]   pkt_out_data,
  output logic               pkt_out_valid,
  input  logic               pkt_out_ready,
  output logic               drop
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_F,
    LOAD_I,
    START,
    WAIT_PSUM,
    SEND,
    WAIT_DONE
  } state_t;

  localparam logic [ADDR_F-1:0] FC_LAST = ADDR_F'(DEPTH_F - 1);
  localparam logic [ADDR_I-1:0] IC_LAST = ADDR_I'(DEPTH_I - 1);

  state_t          state_q, state_d;
  logic [ADDR_F-1:0] fc_q, fc_d;
  logic [ADDR_I-1:0] ic_q, ic_d;
  logic [ADDR_F-1:0] pc_q, pc_d;
  logic            done_seen_q, done_seen_d;
  logic [7:0]      hdr_q, hdr_d;
  logic [4:0]      ifmap_q, ifmap_d;
  logic [2:0][7:0] f_q, f_d;

  logic               pkt_in_ready_d;
  logic               f_we_d;
  logic [ADDR_F-1:0]  f_addr_d;
  logic [WIDTH_F-1:0] f_wdata_d;
  logic               i_we_d;
  logic [ADDR_I-1:0]  i_addr_d;
  logic               i_wdata_d;
  logic               start_d;
  logic               psum_ready_d;
  logic               pkt_out_valid_d;
  logic               drop_d;
  out_pkt_t           out_pkt_d;
  logic [ADDR_F-1:0]  f_sel;
  logic [ADDR_I-1:0]  i_sel;

  in_pkt_t in_pkt;
  logic    in_fire;
  logic    psum_fire;
  logic    out_fire;

  // Ready/valid outputs are registered copies of the state, so they double as handshake qualifiers.
  assign in_pkt    = in_pkt_t'(pkt_in_data);
  assign in_fire   = pkt_in_ready & pkt_in_valid;
  assign psum_fire = psum_ready & psum_valid;
  assign out_fire  = pkt_out_valid & pkt_out_ready;

  // Next state and next registered outputs.
  always_comb begin
    state_d     = state_q;
    fc_d        = fc_q;
    ic_d        = ic_q;
    pc_d        = pc_q;
    done_seen_d = done_seen_q;
    hdr_d       = hdr_q;
    ifmap_d     = ifmap_q;
    f_d         = f_q;
    out_pkt_d   = out_pkt_t'(pkt_out_data);
    drop_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_fire) begin
          if (in_pkt.typ == TYPE_CFG) begin
            hdr_d   = in_pkt.header;
            ifmap_d = in_pkt.ifmap;
            f_d     = in_pkt.f;
            fc_d    = '0;
            state_d = LOAD_F;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      LOAD_F: begin
        if (fc_q == FC_LAST) begin
          fc_d    = '0;
          ic_d    = '0;
          state_d = LOAD_I;
        end else begin
          fc_d = fc_q + ADDR_F'(1);
        end
      end
      LOAD_I: begin
        if (ic_q == IC_LAST) begin
          ic_d    = '0;
          state_d = START;
        end else begin
          ic_d = ic_q + ADDR_I'(1);
        end
      end
      START: begin
        pc_d    = '0;
        state_d = WAIT_PSUM;
      end
      WAIT_PSUM: begin
        if (psum_fire) begin
          out_pkt_d.typ    = TYPE_PSUM;
          out_pkt_d.header = hdr_q;
          out_pkt_d.pad    = 1'b0;
          out_pkt_d.row    = OUT_ROW;
          out_pkt_d.col    = 2'(pc_q + ADDR_F'(1));
          out_pkt_d.zero   = '0;
          out_pkt_d.psum   = psum_data;
          state_d          = SEND;
        end
      end
      SEND: begin
        if (out_fire) begin
          if (pc_q == FC_LAST) begin
            pc_d    = '0;
            state_d = WAIT_DONE;
          end else begin
            pc_d    = pc_q + ADDR_F'(1);
            state_d = WAIT_PSUM;
          end
        end
      end
      WAIT_DONE: begin
        if (done || done_seen_q) begin
          done_seen_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // An early done while the job is running is remembered for WAIT_DONE.
    if (done && (state_q == START || state_q == WAIT_PSUM || state_q == SEND)) begin
      done_seen_d = 1'b1;
    end

    f_sel           = ADDR_F'(2) - fc_d;
    i_sel           = ADDR_I'(4) - ic_d;
    pkt_in_ready_d  = (state_d == IDLE);
    f_we_d          = (state_d == LOAD_F);
    f_addr_d        = f_we_d ? fc_d : '0;
    f_wdata_d       = f_we_d ? WIDTH_F'(f_d[f_sel]) : '0;
    i_we_d          = (state_d == LOAD_I);
    i_addr_d        = i_we_d ? ic_d : '0;
    i_wdata_d       = i_we_d ? ifmap_d[i_sel] : 1'b0;
    start_d         = (state_d == START);
    psum_ready_d    = (state_d == WAIT_PSUM);
    pkt_out_valid_d = (state_d == SEND);
  end

  // State, latches and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      fc_q          <= '0;
      ic_q          <= '0;
      pc_q          <= '0;
      done_seen_q   <= 1'b0;
      hdr_q         <= '0;
      ifmap_q       <= '0;
      f_q           <= '0;
      pkt_in_ready  <= 1'b0;
      f_we          <= 1'b0;
      f_addr        <= '0;
      f_wdata       <= '0;
      i_we          <= 1'b0;
      i_addr        <= '0;
      i_wdata       <= 1'b0;
      start         <= 1'b0;
      psum_ready    <= 1'b0;
      pkt_out_data  <= '0;
      pkt_out_valid <= 1'b0;
      drop          <= 1'b0;
    end else begin
      state_q       <= state_d;
      fc_q          <= fc_d;
      ic_q          <= ic_d;
      pc_q          <= pc_d;
      done_seen_q   <= done_seen_d;
      hdr_q         <= hdr_d;
      ifmap_q       <= ifmap_d;
      f_q           <= f_d;
      pkt_in_ready  <= pkt_in_ready_d;
      f_we          <= f_we_d;
      f_addr        <= f_addr_d;
      f_wdata       <= f_wdata_d;
      i_we          <= i_we_d;
      i_addr        <= i_addr_d;
      i_wdata       <= i_wdata_d;
      start         <= start_d;
      psum_ready    <= psum_ready_d;
      pkt_out_data  <= WIDTH'(out_pkt_d);
      pkt_out_valid <= pkt_out_valid_d;
      drop          <= drop_d;
    end
  end

endmodule

// File: tb/tb_pe_scheduler.sv
// Directed self-checking bench for pe_scheduler: load sequence, psum packets,
// backpressure, early done, dropped packets and reset mid-job.
module tb_pe_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [38:0] pkt_in_data = '0;
  logic        pkt_in_valid = 1'b0;
  logic        pkt_in_ready;
  logic        f_we;
  logic [1:0]  f_addr;
  logic [7:0]  f_wdata;
  logic        i_we;
  logic [2:0]  i_addr;
  logic        i_wdata;
  logic        start;
  logic [7:0]  psum_data = '0;
  logic        psum_valid = 1'b0;
  logic        psum_ready;
  logic        done = 1'b0;
  logic [38:0] pkt_out_data;
  logic        pkt_out_valid;
  logic        pkt_out_ready = 1'b0;
  logic        drop;

  int total = 0;
  int bad   = 0;

  localparam logic [38:0] NOM = {2'b01, 8'h10, 5'b11101, 8'd14, 8'd5, 8'd8};

  pe_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pkt_in_data   (pkt_in_data),
    .pkt_in_valid  (pkt_in_valid),
    .pkt_in_ready  (pkt_in_ready),
    .f_we          (f_we),
    .f_addr        (f_addr),
    .f_wdata       (f_wdata),
    .i_we          (i_we),
    .i_addr        (i_addr),
    .i_wdata       (i_wdata),
    .start         (start),
    .psum_data     (psum_data),
    .psum_valid    (psum_valid),
    .psum_ready    (psum_ready),
    .done          (done),
    .pkt_out_data  (pkt_out_data),
    .pkt_out_valid (pkt_out_valid),
    .pkt_out_ready (pkt_out_ready),
    .drop          (drop)
  );

  always #5 clk = ~clk;

  // Present a packet at a negedge; returns at the negedge after the accept edge (cycle 1).
  task automatic send_cfg(input logic [38:0] p);
    pkt_in_data  = p;
    pkt_in_valid = 1'b1;
    @(negedge clk);
    pkt_in_valid = 1'b0;
    pkt_in_data  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({pkt_in_ready, f_we, i_we, start, psum_ready, pkt_out_valid, drop} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctl: got %b want 0000000",
               {pkt_in_ready, f_we, i_we, start, psum_ready, pkt_out_valid, drop});
    end
    total++;
    if ({f_addr, f_wdata, i_addr, i_wdata} !== 14'd0) begin
      bad++;
      $display("FAIL reset_mem: got %h want 0", {f_addr, f_wdata, i_addr, i_wdata});
    end
    total++;
    if (pkt_out_data !== 39'd0) begin
      bad++;
      $display("FAIL reset_out: got %h want 0", pkt_out_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (pkt_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %b want 1", pkt_in_ready);
    end
  endtask

  // Nominal packet: filter writes cycles 1-3, ifmap writes 4-8, start in 9.
  task automatic test_load(input string tag);
    logic [7:0] fexp [3];
    logic       iexp [5];
    logic       e_f, e_i, e_s;
    fexp = '{8'd14, 8'd5, 8'd8};
    iexp = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    send_cfg(NOM);
    for (int c = 1; c <= 9; c++) begin
      e_f = (c <= 3);
      e_i = (c >= 4) && (c <= 8);
      e_s = (c == 9);
      total++;
      if ({f_we, i_we, start, pkt_in_ready} !== {e_f, e_i, e_s, 1'b0}) begin
        bad++;
        $display("FAIL %s_ctl c%0d: got %b want %b", tag, c,
                 {f_we, i_we, start, pkt_in_ready}, {e_f, e_i, e_s, 1'b0});
      end
      if (e_f) begin
        total++;
        if ({f_addr, f_wdata} !== {2'(c - 1), fexp[c-1]}) begin
          bad++;
          $display("FAIL %s_fwr c%0d: got %0d,%0d want %0d,%0d", tag, c, f_addr, f_wdata,
                   c - 1, fexp[c-1]);
        end
      end
      if (e_i) begin
        total++;
        if ({i_addr, i_wdata} !== {3'(c - 4), iexp[c-4]}) begin
          bad++;
          $display("FAIL %s_iwr c%0d: got %0d,%0d want %0d,%0d", tag, c, i_addr, i_wdata,
                   c - 4, iexp[c-4]);
        end
      end
      @(negedge clk);
    end
    total++;
    if ({start, psum_ready} !== 2'b01) begin
      bad++;
      $display("FAIL %s_wait_psum: got start,psum_ready=%b want 01", tag, {start, psum_ready});
    end
  endtask

  // Psums 7, 20, 3 with the second packet held off for 10 cycles.
  task automatic test_psums();
    logic [38:0] e;
    pkt_out_ready = 1'b1;
    psum_data     = 8'd7;
    psum_valid    = 1'b1;
    @(negedge clk);
    psum_valid = 1'b0;
    e = {2'b10, 8'h10, 1'b0, 2'b01, 2'd1, 16'h0, 8'd7};
    total++;
    if ({pkt_out_valid, psum_ready, pkt_out_data} !== {2'b10, e}) begin
      bad++;
      $display("FAIL psum1_pkt: got v=%b r=%b d=%h want v=1 r=0 d=%h",
               pkt_out_valid, psum_ready, pkt_out_data, e);
    end
    @(negedge clk);
    total++;
    if ({pkt_out_valid, psum_ready} !== 2'b01) begin
      bad++;
      $display("FAIL psum1_xfer: got v,r=%b want 01", {pkt_out_valid, psum_ready});
    end

    pkt_out_ready = 1'b0;
    psum_data     = 8'd20;
    psum_valid    = 1'b1;
    @(negedge clk);
    psum_data  = 8'd3;
    psum_valid = 1'b1;
    e = {2'b10, 8'h10, 1'b0, 2'b01, 2'd2, 16'h0, 8'd20};
    for (int k = 0; k < 10; k++) begin
      total++;
      if ({pkt_out_valid, psum_ready, pkt_out_data} !== {2'b10, e}) begin
        bad++;
        $display("FAIL bp_hold k%0d: got v=%b r=%b d=%h want v=1 r=0 d=%h", k,
                 pkt_out_valid, psum_ready, pkt_out_data, e);
      end
      @(negedge clk);
    end
    pkt_out_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({pkt_out_valid, psum_ready} !== 2'b01) begin
      bad++;
      $display("FAIL bp_release: got v,r=%b want 01", {pkt_out_valid, psum_ready});
    end
    @(negedge clk);
    psum_valid = 1'b0;
    e = {2'b10, 8'h10, 1'b0, 2'b01, 2'd3, 16'h0, 8'd3};
    total++;
    if ({pkt_out_valid, pkt_out_data} !== {1'b1, e}) begin
      bad++;
      $display("FAIL psum3_pkt: got v=%b d=%h want v=1 d=%h", pkt_out_valid, pkt_out_data, e);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({pkt_out_valid, psum_ready, pkt_in_ready} !== 3'b000) begin
        bad++;
        $display("FAIL wait_done k%0d: got v,r,in_ready=%b want 000", k,
                 {pkt_out_valid, psum_ready, pkt_in_ready});
      end
      @(negedge clk);
    end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    total++;
    if (pkt_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL done_idle: got in_ready=%b want 1", pkt_in_ready);
    end
  endtask

  // Done pulsed while the last packet is stalled in SEND.
  task automatic test_early_done();
    logic [38:0] e;
    logic [7:0]  ps [3];
    ps = '{8'd1, 8'd2, 8'd99};
    send_cfg({2'b01, 8'h2A, 5'b01010, 8'd9, 8'd8, 8'd7});
    repeat (9) @(negedge clk);
    pkt_out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      psum_data  = ps[k];
      psum_valid = 1'b1;
      @(negedge clk);
      psum_valid = 1'b0;
      e = {2'b10, 8'h2A, 1'b0, 2'b01, 2'(k + 1), 16'h0, ps[k]};
      total++;
      if ({pkt_out_valid, pkt_out_data} !== {1'b1, e}) begin
        bad++;
        $display("FAIL ed_pkt%0d: got v=%b d=%h want v=1 d=%h", k, pkt_out_valid, pkt_out_data, e);
      end
      @(negedge clk);
    end
    psum_data  = ps[2];
    psum_valid = 1'b1;
    @(negedge clk);
    psum_valid    = 1'b0;
    pkt_out_ready = 1'b0;
    done          = 1'b1;
    e = {2'b10, 8'h2A, 1'b0, 2'b01, 2'd3, 16'h0, 8'd99};
    total++;
    if ({pkt_out_valid, pkt_out_data} !== {1'b1, e}) begin
      bad++;
      $display("FAIL ed_pkt2: got v=%b d=%h want v=1 d=%h", pkt_out_valid, pkt_out_data, e);
    end
    @(negedge clk);
    done          = 1'b0;
    pkt_out_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({pkt_out_valid, pkt_in_ready} !== 2'b00) begin
      bad++;
      $display("FAIL ed_xfer: got v,in_ready=%b want 00", {pkt_out_valid, pkt_in_ready});
    end
    @(negedge clk);
    total++;
    if (pkt_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL ed_idle: got in_ready=%b want 1", pkt_in_ready);
    end
  endtask

  // Non-configuration packets are discarded with a one-cycle drop pulse.
  task automatic test_drop();
    logic [1:0] ty [2];
    logic       quiet;
    ty = '{2'b11, 2'b00};
    for (int t = 0; t < 2; t++) begin
      send_cfg({ty[t], 8'h55, 5'b10101, 8'd1, 8'd2, 8'd3});
      total++;
      if ({drop, pkt_in_ready, f_we} !== 3'b110) begin
        bad++;
        $display("FAIL drop_pulse t%0d: got drop,in_ready,f_we=%b want 110", t,
                 {drop, pkt_in_ready, f_we});
      end
      quiet = 1'b1;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if ({drop, f_we, i_we, start, pkt_in_ready} !== 5'b00001) quiet = 1'b0;
      end
      total++;
      if (quiet !== 1'b1) begin
        bad++;
        $display("FAIL drop_quiet t%0d: got activity after drop want none", t);
      end
    end
  endtask

  // Reset during LOAD_I (ic=2), then a fresh full job from address 0.
  task automatic test_reset_mid_job();
    send_cfg(NOM);
    repeat (5) @(negedge clk);
    total++;
    if ({i_we, i_addr} !== {1'b1, 3'd2}) begin
      bad++;
      $display("FAIL mid_pre: got i_we=%b i_addr=%0d want 1,2", i_we, i_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({pkt_in_ready, f_we, i_we, start, psum_ready, pkt_out_valid, drop, i_addr, i_wdata} !== 11'd0) begin
      bad++;
      $display("FAIL mid_async: got %b want all 0",
               {pkt_in_ready, f_we, i_we, start, psum_ready, pkt_out_valid, drop, i_addr, i_wdata});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({pkt_in_ready, i_we} !== 2'b10) begin
      bad++;
      $display("FAIL mid_release: got in_ready,i_we=%b want 10", {pkt_in_ready, i_we});
    end
    test_load("after_rst");
  endtask

  initial begin
    test_reset();
    test_load("nom");
    test_psums();
    test_early_done();
    test_drop();
    test_reset_mid_job();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pe_scheduler.md
Name: pe_scheduler

Overview:
Clocked sequencer that fronts one PE datapath (filter memory, ifmap memory, MAC logic). It accepts one 39-bit configuration packet from the NoC and unpacks it into filter and ifmap memory writes. It then pulses start, turns each returned psum into a 39-bit output packet, and waits for done before accepting the next packet. It sits between the router port and the PE logic block.

Parameters:
WIDTH, 39, packet width
WIDTH_F, 8, filter word width
DEPTH_F, 3, filter words per packet and psums per job (legal range 1..3)
DEPTH_I, 5, ifmap bits per packet
ADDR_F, 2, filter memory address width
ADDR_I, 3, ifmap memory address width
OUT_ROW, 2'b01, row tag inserted in output packets

Ports:
clk  in  1  clock, all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
pkt_in_data  in  WIDTH  packet fields: [38:37] type, [36:29] header, [28:24] ifmap bits (bit 28 = ifmap[0]), [23:16] f[0], [15:8] f[1], [7:0] f[2]
pkt_in_valid  in  1  input packet valid
pkt_in_ready  out  1  scheduler can accept a packet
f_we  out  1  filter memory write enable
f_addr  out  ADDR_F  filter write address
f_wdata  out  WIDTH_F  filter write data
i_we  out  1  ifmap memory write enable
i_addr  out  ADDR_I  ifmap write address
i_wdata  out  1  ifmap write data
start  out  1  one-cycle compute start pulse
psum_data  in  8  partial sum from the PE
psum_valid  in  1  partial sum valid
psum_ready  out  1  scheduler accepts a psum
done  in  1  one-cycle job-complete pulse from the PE
pkt_out_data  out  WIDTH  output packet
pkt_out_valid  out  1  output packet valid
pkt_out_ready  in  1  downstream accepts the output packet
drop  out  1  one-cycle pulse when a packet is discarded

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE. All outputs are 0, including pkt_in_ready, pkt_out_data, and all counters and latches. Reset asserted mid-job aborts the job immediately with no further memory writes or packets. Any in-flight handshakes are abandoned.
- Handshakes are valid/ready: a transfer occurs on a rising edge where both are 1. A valid signal, once high, holds its data stable until the transfer.
- IDLE: pkt_in_ready=1.
  - On accept with type==2'b01: latch the packet, filter count fc=0, go to LOAD_F.
  - On accept with any other type: pulse drop for one cycle next cycle and stay in IDLE.
- LOAD_F: for DEPTH_F cycles, f_we=1, f_addr=fc, f_wdata=f[fc]. Then go to LOAD_I with ic=0.
- LOAD_I: for DEPTH_I cycles, i_we=1, i_addr=ic, i_wdata=ifmap[ic]. Then go to START.
- START: start=1 for exactly one cycle, psum count pc=0, then go to WAIT_PSUM.
- Latency with default parameters (accept edge = cycle 0):
  - filter writes in cycles 1-3
  - ifmap writes in cycles 4-8
  - start high in cycle 9
- WAIT_PSUM: psum_ready=1. On psum accept, build pkt_out_data and go to SEND:
  - [38:37]=2'b10
  - [36:29]=latched header
  - [28:24]={1'b0, OUT_ROW, col} where col = pc+1, truncated to 2 bits
  - [23:8]=0
  - [7:0]=psum_data
- SEND: pkt_out_valid=1 and data held stable.
  - On accept with pc==DEPTH_F-1: go to WAIT_DONE.
  - Otherwise: increment pc and return to WAIT_PSUM.
  - psum_ready=0 while in SEND, so at most one psum is buffered.
- WAIT_DONE: on done, or if done_seen is set, clear done_seen and go to IDLE.
  - Counters return to 0.
  - pkt_in_ready rises the cycle after done is observed.
- done_seen: a done pulse arriving in any state from START through SEND sets this sticky flag, so an early done is never lost. A done pulse in IDLE, LOAD_F or LOAD_I is ignored.
- psum_valid outside WAIT_PSUM is not acknowledged; the PE must hold it.
- pkt_in_ready=0 in every state except IDLE.
- Only one job is in flight at a time.

Test Plan:
- Nominal job. Send packet 01_00010000_11101_00001110_00000101_00001000.
  - Required: f writes (0,14), (1,5), (2,8) in cycles 1-3.
  - Required: i writes (0,1), (1,1), (2,1), (3,0), (4,1) in cycles 4-8.
  - Required: start in cycle 9.
- Psum packets. After the nominal job, return psums 7, 20, 3.
  - Required: output packets 10_00010000_00101_0..0_00000111, then col=2 with 20, then col=3 with 3.
  - Required: done then returns to IDLE.
- Backpressure. Hold pkt_out_ready=0 for 10 cycles on the second psum.
  - Required: pkt_out_data is stable and psum_ready=0 throughout.
  - Required: the third psum is not accepted until the second packet transfers.
- Early done. Pulse done while in SEND for the last psum.
  - Required: after that packet transfers, state reaches IDLE with no further wait for done.
- Dropped packet. Send a type 2'b11 packet.
  - Required: drop pulses for one cycle, with no memory writes and no start.
- Reset mid-job. Deassert rst_n during LOAD_I (ic=2).
  - Required: outputs clear asynchronously.
  - Required: after release, a fresh packet runs the full nominal sequence from address 0.
